// File: rtl/cordic_sweep_if.sv
// Sweep request, CORDIC engine handshake and result stream bundled for cordic_sweep.
// master is the sequencer's view; slave is the environment (requester, engine, sink).
interface cordic_sweep_if;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  req_start_deg;
    logic [8:0]  req_step;
    logic [9:0]  req_count;
    logic        cordic_start;
    logic [8:0]  cordic_degree;
    logic [11:0] cordic_cos;
    logic [11:0] cordic_sin;
    logic        cordic_done;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_degree;
    logic [11:0] out_cos;
    logic [11:0] out_sin;
    logic        out_last;
    logic        busy;

    modport master (
        input  req_valid, req_start_deg, req_step, req_count,
               cordic_cos, cordic_sin, cordic_done, out_ready,
        output req_ready, cordic_start, cordic_degree,
               out_valid, out_degree, out_cos, out_sin, out_last, busy
    );

    modport slave (
        output req_valid, req_start_deg, req_step, req_count,
               cordic_cos, cordic_sin, cordic_done, out_ready,
        input  req_ready, cordic_start, cordic_degree,
               out_valid, out_degree, out_cos, out_sin, out_last, busy
    );
endinterface

// File: rtl/cordic_sweep.sv
// Angle-sweep sequencer for an iterative CORDIC engine: issues one angle at a time
// and buffers each cos/sin result in a small FIFO presented as a valid/ready stream.
module cordic_sweep #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    cordic_sweep_if.master bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    typedef struct packed {
        logic [8:0]  deg;
        logic [11:0] cos;
        logic [11:0] sin;
        logic        last;
    } ent_t;

    function automatic logic [8:0] norm(input logic [8:0] a);
        return (a >= 9'd360) ? a - 9'd360 : a;
    endfunction

    state_t      state_q;
    logic [8:0]  cur_q, step_q, deg_q;
    logic [9:0]  rem_q;
    logic        start_q;

    ent_t        mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q, cnt_d;

    logic        push, pop, can_issue;
    logic [9:0]  sum_w;
    logic [8:0]  next_deg;
    ent_t        head;

    assign sum_w    = {1'b0, cur_q} + {1'b0, step_q};
    assign next_deg = (sum_w >= 10'd360) ? 9'(sum_w - 10'd360) : sum_w[8:0];

    assign push      = (state_q == WAIT) && bus.cordic_done;
    assign pop       = bus.out_valid && bus.out_ready;
    // A slot being popped this cycle is as good as free.
    assign can_issue = (cnt_q != FULL) || pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            start_q <= 1'b0;
            deg_q   <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.req_valid) begin
                    cur_q   <= norm(bus.req_start_deg);
                    step_q  <= norm(bus.req_step);
                    rem_q   <= bus.req_count;
                    state_q <= (bus.req_count == 10'd0) ? IDLE : ISSUE;
                end
                ISSUE: if (can_issue) begin
                    start_q <= 1'b1;
                    deg_q   <= cur_q;
                    state_q <= WAIT;
                end
                WAIT: if (bus.cordic_done) begin
                    rem_q <= rem_q - 10'd1;
                    if (rem_q == 10'd1) begin
                        state_q <= IDLE;
                    end else begin
                        cur_q   <= next_deg;
                        state_q <= GAP;
                    end
                end
                // Lets the engine settle back to its initial state before the next start.
                GAP:     state_q <= ISSUE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= {cur_q, bus.cordic_cos, bus.cordic_sin, rem_q == 10'd1};
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    assign head = mem_q[rd_q];

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.cordic_start  = start_q;
    assign bus.cordic_degree = deg_q;
    assign bus.out_valid     = (cnt_q != '0);
    assign bus.out_degree    = head.deg;
    assign bus.out_cos       = head.cos;
    assign bus.out_sin       = head.sin;
    assign bus.out_last      = head.last;
endmodule

// File: tb/tb_cordic_sweep.sv
// Directed bench for cordic_sweep with a fixed-latency behavioural CORDIC engine.
module tb_cordic_sweep;
    localparam int LAT = 4;

    typedef struct {
        logic [8:0]  deg;
        logic [11:0] c;
        logic [11:0] s;
        logic        last;
    } ent_t;

    logic clk, rst;
    cordic_sweep_if ifc ();

    cordic_sweep #(.FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0, total = 0, proto_err = 0;
    ent_t cap[$];
    logic [8:0] starts[$];

    function automatic logic [11:0] q10(input real r);
        real v;
        int  i;
        v = r * 1024.0;
        i = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        return 12'(i);
    endfunction

    function automatic real rad(input logic [8:0] d);
        return real'(d) * 3.14159265358979 / 180.0;
    endfunction

    // Behavioural engine: latches the angle on start, pulses done LAT cycles later.
    int eng_cnt = 0;
    logic [8:0]  eng_deg;
    logic        eng_done = 1'b0, inj_done = 1'b0;
    logic [11:0] eng_cos = '0, eng_sin = '0;
    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (ifc.cordic_start) begin
            eng_cnt <= LAT;
            eng_deg <= ifc.cordic_degree;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_done <= 1'b1;
                eng_cos  <= q10($cos(rad(eng_deg)));
                eng_sin  <= q10($sin(rad(eng_deg)));
            end
        end
    end
    assign ifc.cordic_done = eng_done | inj_done;
    assign ifc.cordic_cos  = inj_done ? 12'h3AB : eng_cos;
    assign ifc.cordic_sin  = inj_done ? 12'h155 : eng_sin;

    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            if (ifc.out_valid && ifc.out_ready)
                cap.push_back('{ifc.out_degree, ifc.out_cos, ifc.out_sin, ifc.out_last});
            if (ifc.cordic_start) begin
                starts.push_back(ifc.cordic_degree);
                if (eng_cnt != 0 || ifc.cordic_done || prev_done) proto_err++;
            end
        end
        prev_done = ifc.cordic_done;
    end

    task automatic send_req(input int s, input int st, input int c);
        int n = 0;
        while (!ifc.req_ready && n < 1000) begin @(posedge clk); #1; n++; end
        ifc.req_start_deg = 9'(s);
        ifc.req_step      = 9'(st);
        ifc.req_count     = 10'(c);
        ifc.req_valid     = 1'b1;
        @(posedge clk); #1;
        ifc.req_valid     = 1'b0;
    endtask

    task automatic wait_out(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (cap.size() >= n && !ifc.busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        total++; if ({ifc.req_ready, ifc.cordic_start, ifc.busy, ifc.out_valid} !== 4'b1000)
            $display("FAIL reset_ctrl got %b want 1000", {ifc.req_ready, ifc.cordic_start, ifc.busy, ifc.out_valid}); else pass_cnt++;
        total++; if (ifc.cordic_degree !== 9'd0)
            $display("FAIL reset_degree got %0d want 0", ifc.cordic_degree); else pass_cnt++;
        total++; if ({ifc.out_degree, ifc.out_cos, ifc.out_sin, ifc.out_last} !== 34'd0)
            $display("FAIL reset_out got %h want 0", {ifc.out_degree, ifc.out_cos, ifc.out_sin, ifc.out_last}); else pass_cnt++;
    endtask

    task automatic test_quadrants();
        int cb = cap.size(), sb = starts.size();
        int ec[4] = '{1024, 0, -1024, 0};
        int es[4] = '{0, 1024, 0, -1024};
        int dg[4] = '{0, 90, 180, 270};
        bit ok;
        ifc.out_ready = 1'b1;
        send_req(0, 90, 4);
        wait_out(cb + 4, 400, ok);
        total++; if (!ok) $display("FAIL quad_timeout got %0d entries want 4", cap.size() - cb); else pass_cnt++;
        total++; if (starts.size() - sb != 4) $display("FAIL quad_starts got %0d want 4", starts.size() - sb); else pass_cnt++;
        for (int i = 0; i < 4 && cb + i < cap.size(); i++) begin
            ent_t e = cap[cb + i];
            int dc = int'($signed(e.c)) - ec[i];
            int ds = int'($signed(e.s)) - es[i];
            total++; if (e.deg !== 9'(dg[i])) $display("FAIL quad_deg[%0d] got %0d want %0d", i, e.deg, dg[i]); else pass_cnt++;
            total++; if (dc < -2 || dc > 2) $display("FAIL quad_cos[%0d] got %0d want %0d", i, $signed(e.c), ec[i]); else pass_cnt++;
            total++; if (ds < -2 || ds > 2) $display("FAIL quad_sin[%0d] got %0d want %0d", i, $signed(e.s), es[i]); else pass_cnt++;
            total++; if (e.last !== (i == 3)) $display("FAIL quad_last[%0d] got %b want %b", i, e.last, i == 3); else pass_cnt++;
        end
        total++; if (ifc.busy !== 1'b0) $display("FAIL quad_busy got %b want 0", ifc.busy); else pass_cnt++;
    endtask

    task automatic test_wrap(input int s, input int st, input int d0, input int d1, input int d2, input int n);
        int cb = cap.size(), sb = starts.size();
        int dg[3] = '{d0, d1, d2};
        bit ok;
        send_req(s, st, n);
        wait_out(cb + n, 400, ok);
        total++; if (!ok) $display("FAIL wrap_timeout got %0d entries want %0d", cap.size() - cb, n); else pass_cnt++;
        for (int i = 0; i < n && sb + i < starts.size(); i++) begin
            total++; if (starts[sb + i] !== 9'(dg[i])) $display("FAIL wrap_engine_deg[%0d] got %0d want %0d", i, starts[sb + i], dg[i]); else pass_cnt++;
        end
        for (int i = 0; i < n && cb + i < cap.size(); i++) begin
            total++; if (cap[cb + i].deg !== 9'(dg[i]) || cap[cb + i].last !== (i == n - 1))
                $display("FAIL wrap_out[%0d] got %0d/%b want %0d/%b", i, cap[cb + i].deg, cap[cb + i].last, dg[i], i == n - 1); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int cb = cap.size(), sb = starts.size();
        bit ok;
        ifc.out_ready = 1'b0;
        send_req(0, 1, 8);
        repeat (80) @(posedge clk);
        #1;
        total++; if (starts.size() - sb != 4) $display("FAIL bp_stall_starts got %0d want 4", starts.size() - sb); else pass_cnt++;
        total++; if ({ifc.out_valid, ifc.busy, ifc.out_degree} !== {2'b11, 9'd0})
            $display("FAIL bp_stall_state got %b%b/%0d want 11/0", ifc.out_valid, ifc.busy, ifc.out_degree); else pass_cnt++;
        ifc.out_ready = 1'b1;
        wait_out(cb + 8, 400, ok);
        total++; if (!ok || cap.size() - cb != 8) $display("FAIL bp_count got %0d want 8", cap.size() - cb); else pass_cnt++;
        total++; if (starts.size() - sb != 8) $display("FAIL bp_starts got %0d want 8", starts.size() - sb); else pass_cnt++;
        for (int i = 0; i < 8 && cb + i < cap.size(); i++) begin
            ent_t e = cap[cb + i];
            int ds = int'($signed(e.s)) - int'($signed(q10($sin(rad(9'(i))))));
            total++; if (e.deg !== 9'(i) || e.last !== (i == 7) || ds < -2 || ds > 2)
                $display("FAIL bp_entry[%0d] got %0d/%b/%0d want %0d/%b", i, e.deg, e.last, $signed(e.s), i, i == 7); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int cb = cap.size();
        int dg[4] = '{0, 90, 180, 270};
        bit ok;
        send_req(0, 90, 2);
        send_req(180, 90, 2);
        wait_out(cb + 4, 400, ok);
        total++; if (!ok) $display("FAIL b2b_timeout got %0d entries want 4", cap.size() - cb); else pass_cnt++;
        for (int i = 0; i < 4 && cb + i < cap.size(); i++) begin
            total++; if (cap[cb + i].deg !== 9'(dg[i]) || cap[cb + i].last !== (i % 2 == 1))
                $display("FAIL b2b_out[%0d] got %0d/%b want %0d/%b", i, cap[cb + i].deg, cap[cb + i].last, dg[i], i % 2 == 1); else pass_cnt++;
        end
    endtask

    task automatic test_count_zero();
        int sb = starts.size();
        send_req(10, 10, 0);
        total++; if ({ifc.req_ready, ifc.busy} !== 2'b10) $display("FAIL zero_ready got %b%b want 10", ifc.req_ready, ifc.busy); else pass_cnt++;
        repeat (20) @(posedge clk);
        #1;
        total++; if (starts.size() != sb || ifc.out_valid !== 1'b0)
            $display("FAIL zero_activity got %0d starts valid=%b want 0/0", starts.size() - sb, ifc.out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int sb = starts.size(), cb, sb2;
        bit ok;
        send_req(0, 10, 6);
        for (int i = 0; i < 500 && starts.size() - sb < 3; i++) @(negedge clk);
        total++; if (starts.size() - sb != 3) $display("FAIL rmid_reach got %0d starts want 3", starts.size() - sb); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++; if ({ifc.req_ready, ifc.cordic_start, ifc.busy, ifc.out_valid, ifc.cordic_degree} !== {4'b1000, 9'd0})
            $display("FAIL rmid_ctrl got %b/%0d want 1000/0", {ifc.req_ready, ifc.cordic_start, ifc.busy, ifc.out_valid}, ifc.cordic_degree); else pass_cnt++;
        total++; if ({ifc.out_degree, ifc.out_cos, ifc.out_sin, ifc.out_last} !== 34'd0)
            $display("FAIL rmid_out got %h want 0", {ifc.out_degree, ifc.out_cos, ifc.out_sin, ifc.out_last}); else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b1;
        cb = cap.size();
        repeat (8) @(posedge clk);
        #1 inj_done = 1'b1;
        @(posedge clk); #1 inj_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        total++; if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0 || cap.size() != cb)
            $display("FAIL rmid_stale_done got valid=%b busy=%b want 0/0", ifc.out_valid, ifc.busy); else pass_cnt++;
        sb2 = starts.size();
        send_req(45, 0, 1);
        wait_out(cb + 1, 200, ok);
        total++; if (!ok || cap.size() != cb + 1 || starts.size() - sb2 != 1)
            $display("FAIL rmid_new_count got %0d entries %0d starts want 1/1", cap.size() - cb, starts.size() - sb2);
        else begin
            int dc = int'($signed(cap[cb].c)) - 724;
            int ds = int'($signed(cap[cb].s)) - 724;
            pass_cnt++;
            total++; if (cap[cb].deg !== 9'd45 || cap[cb].last !== 1'b1)
                $display("FAIL rmid_entry got %0d/%b want 45/1", cap[cb].deg, cap[cb].last); else pass_cnt++;
            total++; if (dc < -2 || dc > 2 || ds < -2 || ds > 2)
                $display("FAIL rmid_trig got %0d/%0d want 724/724", $signed(cap[cb].c), $signed(cap[cb].s)); else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b0;
        ifc.req_valid = 1'b0;
        ifc.req_start_deg = '0;
        ifc.req_step = '0;
        ifc.req_count = '0;
        ifc.out_ready = 1'b1;
        #2;
        test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        test_quadrants();
        test_wrap(350, 20, 350, 10, 30, 3);
        test_wrap(400, 450, 40, 130, 0, 2);
        test_backpressure();
        test_back_to_back();
        test_count_zero();
        test_reset_mid();
        total++; if (proto_err != 0) $display("FAIL engine_protocol got %0d violations want 0", proto_err); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
